// File: rtl/mips_decode_pkg.sv
// Shared decode definitions: opcodes, FSM states and the decoded-field bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: opcode constants for the supported MIPS32 subset, the decode FSM
// state type, the decoded-field struct and a sign-extension helper.
package mips_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ISSUE = 2'd3
  } state_e;

  // rs/rt travel with the decoded fields so the hazard check reads one bundle.
  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        writes;
    logic        uses_rs;
    logic        uses_rt;
    logic [31:0] imm;
    logic        illegal;
  } fields_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/instr_fields.sv
// Combinational instruction field decoder for the MIPS32 subset.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input.
//
// Ports: instr_i - 32-bit instruction word; fields_o - decoded bundle
// (source usage, destination, write enable, extended immediate, illegal flag).
module instr_fields
  import mips_decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output fields_t     fields_o
);

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;

  assign opcode = instr_i[31:26];
  assign rs     = instr_i[25:21];
  assign rt     = instr_i[20:16];
  assign rd     = instr_i[15:11];
  assign imm16  = instr_i[15:0];

  always_comb begin
    fields_o    = '0;
    fields_o.rs = rs;
    fields_o.rt = rt;
    case (opcode)
      OP_RTYPE: begin
        fields_o.dest    = rd;
        fields_o.writes  = 1'b1;
        fields_o.uses_rs = 1'b1;
        fields_o.uses_rt = 1'b1;
        fields_o.imm     = sext16(imm16);
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
        fields_o.dest    = rt;
        fields_o.writes  = 1'b1;
        fields_o.uses_rs = 1'b1;
        fields_o.imm     = sext16(imm16);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        fields_o.dest    = rt;
        fields_o.writes  = 1'b1;
        fields_o.uses_rs = 1'b1;
        fields_o.imm     = {16'h0000, imm16};
      end
      OP_LUI: begin
        fields_o.dest   = rt;
        fields_o.writes = 1'b1;
        fields_o.imm    = {imm16, 16'h0000};
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        fields_o.uses_rs = 1'b1;
        fields_o.uses_rt = 1'b1;
        fields_o.imm     = sext16(imm16);
      end
      OP_J: begin
        fields_o.imm = '0;
      end
      OP_JAL: begin
        fields_o.dest   = REG_RA;
        fields_o.writes = 1'b1;
      end
      default: begin
        fields_o.illegal = 1'b1;
      end
    endcase
    // $0 is hardwired; a "write" to it must never reach the scoreboard.
    if (fields_o.dest == 5'd0) begin
      fields_o.writes = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: latches one instruction, reads the register file, stalls on a write-pending scoreboard, issues to execute.
// Latency: 3 cycles from accept to ex_valid with no hazard; one instruction per 4 cycles at best.
// Backpressure: ex_* held stable while ex_ready=0; if_ready only in IDLE, so fetch stalls until issue completes.
//
// Ports: clock/reset (sync, active-high); if_* fetch handshake; rnum1/rnum2 to
// the register file with rdata1/rdata2 returned one cycle later; wb_write/
// wb_wnum retire scoreboard entries; ex_* decoded operand bundle with
// ex_valid/ex_ready handshake.
module decode_stage
  import mips_decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic [4:0]  rnum1,
  output logic [4:0]  rnum2,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic        wb_write,
  input  logic [4:0]  wb_wnum,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [5:0]  ex_opcode,
  output logic [5:0]  ex_funct,
  output logic [4:0]  ex_shamt,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_dest,
  output logic        ex_writes,
  output logic        ex_illegal
);

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pending_q, pending_d;

  logic        ex_valid_q;
  logic [31:0] ex_pc_q;
  logic [5:0]  ex_opcode_q;
  logic [5:0]  ex_funct_q;
  logic [4:0]  ex_shamt_q;
  logic [31:0] ex_rs_val_q;
  logic [31:0] ex_rt_val_q;
  logic [31:0] ex_imm_q;
  logic [4:0]  ex_dest_q;
  logic        ex_writes_q;
  logic        ex_illegal_q;

  fields_t     fields;
  logic        accept;
  logic        hazard;
  logic        issue_fire;

  instr_fields u_instr_fields (
    .instr_i  (instr_q),
    .fields_o (fields)
  );

  // Read numbers come straight from the latched instruction, so they stay
  // stable from acceptance until the next instruction is accepted.
  assign rnum1 = instr_q[25:21];
  assign rnum2 = instr_q[20:16];

  assign if_ready   = (state_q == ST_IDLE) && !reset;
  assign accept     = (state_q == ST_IDLE) && if_valid;
  assign issue_fire = (state_q == ST_ISSUE) && ex_ready;

  // Registered scoreboard only: a writeback at this edge is seen next cycle.
  assign hazard = (fields.uses_rs && pending_q[fields.rs]) ||
                  (fields.uses_rt && pending_q[fields.rt]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (if_valid) state_d = ST_READ;
      ST_READ:  if (!hazard)  state_d = ST_WAIT;
      ST_WAIT:                state_d = ST_ISSUE;
      ST_ISSUE: if (ex_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Clear first, then set, so an issue and a writeback to the same register
  // on one edge leave the bit pending.
  always_comb begin
    pending_d = pending_q;
    if (wb_write) begin
      pending_d[wb_wnum] = 1'b0;
    end
    if (issue_fire && ex_writes_q) begin
      pending_d[ex_dest_q] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      pc_q         <= '0;
      pending_q    <= '0;
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_opcode_q  <= '0;
      ex_funct_q   <= '0;
      ex_shamt_q   <= '0;
      ex_rs_val_q  <= '0;
      ex_rt_val_q  <= '0;
      ex_imm_q     <= '0;
      ex_dest_q    <= '0;
      ex_writes_q  <= 1'b0;
      ex_illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (accept) begin
        instr_q <= if_instr;
        pc_q    <= if_pc;
      end
      if (state_q == ST_WAIT) begin
        // Register file data sampled at the READ->WAIT edge is valid now.
        ex_valid_q   <= 1'b1;
        ex_pc_q      <= pc_q;
        ex_opcode_q  <= instr_q[31:26];
        ex_funct_q   <= instr_q[5:0];
        ex_shamt_q   <= instr_q[10:6];
        ex_rs_val_q  <= rdata1;
        ex_rt_val_q  <= rdata2;
        ex_imm_q     <= fields.imm;
        ex_dest_q    <= fields.dest;
        ex_writes_q  <= fields.writes;
        ex_illegal_q <= fields.illegal;
      end else if (issue_fire) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_opcode  = ex_opcode_q;
  assign ex_funct   = ex_funct_q;
  assign ex_shamt   = ex_shamt_q;
  assign ex_rs_val  = ex_rs_val_q;
  assign ex_rt_val  = ex_rt_val_q;
  assign ex_imm     = ex_imm_q;
  assign ex_dest    = ex_dest_q;
  assign ex_writes  = ex_writes_q;
  assign ex_illegal = ex_illegal_q;

endmodule
